// File: rtl/gas_warn_monitor_pkg.sv
// Shared types and defaults for the multi-channel gas warning monitor.
package gas_warn_monitor_pkg;

  typedef enum logic [1:0] {
    SAFE      = 2'd0,
    PEND_WARN = 2'd1,
    WARN      = 2'd2,
    PEND_SAFE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_DEBOUNCE = 3;

  // Counter must hold values 0..DEBOUNCE.
  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/gas_warn_channel.sv
// One sensor channel: hysteresis compare, debounce FSM and sticky alarm.
module gas_warn_channel
  import gas_warn_monitor_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sample,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] thresh_on,
  input  logic signed [WIDTH-1:0] thresh_off,
  input  logic                    ack,
  output logic                    warn,
  output logic                    alarm_latched
);

  localparam int            CW  = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          warn_nxt;
  logic          alarm_nxt;
  logic          low;
  logic          recovered;

  assign low       = sample < thresh_on;
  assign recovered = sample >= thresh_off;

  // State, debounce counter and sticky alarm registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= SAFE;
      cnt           <= '0;
      alarm_latched <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      alarm_latched <= alarm_nxt;
    end
  end

  // Next state: only the test relevant to the current side of the window is used.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (sample_valid) begin
      unique case (state)
        SAFE: begin
          if (low) begin
            if (DEBOUNCE == 1) begin
              state_nxt = WARN;
              cnt_nxt   = '0;
            end else begin
              state_nxt = PEND_WARN;
              cnt_nxt   = ONE;
            end
          end
        end
        PEND_WARN: begin
          if (!low) begin
            state_nxt = SAFE;
            cnt_nxt   = '0;
          end else if (cnt + ONE == DEB) begin
            state_nxt = WARN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        WARN: begin
          if (recovered) begin
            if (DEBOUNCE == 1) begin
              state_nxt = SAFE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = PEND_SAFE;
              cnt_nxt   = ONE;
            end
          end
        end
        PEND_SAFE: begin
          if (!recovered) begin
            state_nxt = WARN;
            cnt_nxt   = '0;
          end else if (cnt + ONE == DEB) begin
            state_nxt = SAFE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      endcase
    end
  end

  // Outputs: warn decodes the registered state; alarm sets on warn's rising edge (set beats ack).
  always_comb begin
    warn      = (state == WARN) || (state == PEND_SAFE);
    warn_nxt  = (state_nxt == WARN) || (state_nxt == PEND_SAFE);
    alarm_nxt = alarm_latched;
    if (warn_nxt && !warn) begin
      alarm_nxt = 1'b1;
    end else if (ack) begin
      alarm_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/gas_warn_monitor.sv
// Multi-channel gas warning monitor: per-channel debounce FSMs plus a registered any-warning flag.
module gas_warn_monitor
  import gas_warn_monitor_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic [CHANNELS-1:0]       sample_valid,
  input  logic signed [WIDTH-1:0]   thresh_on,
  input  logic signed [WIDTH-1:0]   thresh_off,
  input  logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       warn,
  output logic                      warn_any,
  output logic [CHANNELS-1:0]       alarm_latched
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gas_warn_channel #(
      .WIDTH   (WIDTH),
      .DEBOUNCE(DEBOUNCE)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .sample       (sample[i*WIDTH +: WIDTH]),
      .sample_valid (sample_valid[i]),
      .thresh_on    (thresh_on),
      .thresh_off   (thresh_off),
      .ack          (ack[i]),
      .warn         (warn[i]),
      .alarm_latched(alarm_latched[i])
    );
  end

  // Registered OR of all channel warnings.
  always_ff @(posedge clock) begin
    if (reset) begin
      warn_any <= 1'b0;
    end else begin
      warn_any <= |warn;
    end
  end

endmodule

// File: tb/tb_gas_warn_monitor.sv
// Self-checking bench for gas_warn_monitor: directed scenarios plus randomized traffic vs. a run-length model.
module tb_gas_warn_monitor;

  localparam int CH  = 4;
  localparam int W   = 32;
  localparam int DEB = 3;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [CH*W-1:0]       sample;
  logic [CH-1:0]         sample_valid;
  logic signed [W-1:0]   thresh_on;
  logic signed [W-1:0]   thresh_off;
  logic [CH-1:0]         ack;
  logic [CH-1:0]         warn;
  logic                  warn_any;
  logic [CH-1:0]         alarm_latched;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel warning flag and length of the current qualifying run.
  bit m_warn  [CH];
  int m_run   [CH];
  bit m_alarm [CH];
  bit m_any;

  gas_warn_monitor #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .DEBOUNCE(DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .thresh_on    (thresh_on),
    .thresh_off   (thresh_off),
    .ack          (ack),
    .warn         (warn),
    .warn_any     (warn_any),
    .alarm_latched(alarm_latched)
  );

  always #5 clock = ~clock;

  task automatic model_update();
    bit any_prev;
    bit old_w;
    logic signed [W-1:0] s;
    any_prev = 1'b0;
    for (int i = 0; i < CH; i++) any_prev |= m_warn[i];
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_warn[i] = 0; m_run[i] = 0; m_alarm[i] = 0;
      end
      m_any = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        old_w = m_warn[i];
        if (sample_valid[i]) begin
          s = sample[i*W +: W];
          if (m_warn[i] ? (s >= thresh_off) : (s < thresh_on)) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_warn[i] = !m_warn[i];
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        if (m_warn[i] && !old_w) m_alarm[i] = 1;
        else if (ack[i])         m_alarm[i] = 0;
      end
      m_any = any_prev;
    end
  endtask

  // Advance one clock; inputs are stable across the edge, outputs are sampled 1ns later.
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    sample_valid = '0;
    ack          = '0;
  endtask

  task automatic drive(input int ch, input int val);
    idle();
    sample[ch*W +: W] = W'(val);
    sample_valid[ch]  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (warn !== 4'b0000) begin errors++; $display("FAIL reset_warn got %b want 0000", warn); end
    checks++;
    if (alarm_latched !== 4'b0000) begin errors++; $display("FAIL reset_alarm got %b want 0000", alarm_latched); end
    checks++;
    if (warn_any !== 1'b0) begin errors++; $display("FAIL reset_warn_any got %b want 0", warn_any); end
  endtask

  task automatic test_raise();
    drive(0, 9); step();
    drive(0, 8); step();
    checks++;
    if (warn !== 4'b0000) begin errors++; $display("FAIL raise_early got %b want 0000", warn); end
    drive(0, 7); step();
    checks++;
    if (warn !== 4'b0001) begin errors++; $display("FAIL raise_warn got %b want 0001", warn); end
    checks++;
    if (alarm_latched !== 4'b0001) begin errors++; $display("FAIL raise_alarm got %b want 0001", alarm_latched); end
    checks++;
    if (warn_any !== 1'b0) begin errors++; $display("FAIL raise_any_lag got %b want 0", warn_any); end
    idle(); step();
    checks++;
    if (warn_any !== 1'b1) begin errors++; $display("FAIL raise_any got %b want 1", warn_any); end
  endtask

  task automatic test_break();
    int seq[6] = '{9, 9, 12, 9, 9, 9};
    for (int k = 0; k < 6; k++) begin
      drive(1, seq[k]); step();
      if (k == 4) begin
        checks++;
        if (warn[1] !== 1'b0) begin errors++; $display("FAIL break_run got %b want 0", warn[1]); end
      end
    end
    checks++;
    if (warn[1] !== 1'b1) begin errors++; $display("FAIL break_rewarn got %b want 1", warn[1]); end
  endtask

  task automatic test_hysteresis();
    int seq[5] = '{12, 13, 15, 20, 16};
    for (int k = 0; k < 5; k++) begin
      drive(0, seq[k]); step();
      if (k == 1 || k == 3) begin
        checks++;
        if (warn[0] !== 1'b1) begin errors++; $display("FAIL hyst_hold k=%0d got %b want 1", k, warn[0]); end
      end
    end
    checks++;
    if (warn[0] !== 1'b0) begin errors++; $display("FAIL hyst_clear got %b want 0", warn[0]); end
    checks++;
    if (alarm_latched[0] !== 1'b1) begin errors++; $display("FAIL hyst_alarm_sticky got %b want 1", alarm_latched[0]); end
  endtask

  task automatic test_invalid_hold();
    drive(2, 5); step();
    idle();
    for (int k = 0; k < 4; k++) step();
    drive(2, 5); step();
    checks++;
    if (warn[2] !== 1'b0) begin errors++; $display("FAIL invalid_early got %b want 0", warn[2]); end
    drive(2, 5); step();
    checks++;
    if (warn[2] !== 1'b1) begin errors++; $display("FAIL invalid_hold got %b want 1", warn[2]); end
  endtask

  task automatic test_ack();
    do_reset();
    drive(0, 9); step();
    drive(0, 8); step();
    drive(0, 7); ack[0] = 1'b1; step();
    checks++;
    if (alarm_latched[0] !== 1'b1) begin errors++; $display("FAIL ack_set_wins got %b want 1", alarm_latched[0]); end
    idle(); ack[0] = 1'b1; step();
    checks++;
    if (alarm_latched[0] !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", alarm_latched[0]); end
    checks++;
    if (warn[0] !== 1'b1) begin errors++; $display("FAIL ack_warn_kept got %b want 1", warn[0]); end
    idle(); step();
    checks++;
    if (alarm_latched[0] !== 1'b0) begin errors++; $display("FAIL ack_no_reset got %b want 0", alarm_latched[0]); end
  endtask

  task automatic test_reset_mid();
    drive(3, 9); step();
    drive(3, 9); step();
    do_reset();
    checks++;
    if ({warn, alarm_latched, warn_any} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid got warn=%b alarm=%b any=%b want 0", warn, alarm_latched, warn_any);
    end
    drive(3, 9); step();
    checks++;
    if (warn[3] !== 1'b0) begin errors++; $display("FAIL reset_mid_cnt got %b want 0", warn[3]); end
  endtask

  task automatic test_random();
    logic [CH-1:0] ew, ea;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) begin
        thresh_on  = W'(int'($urandom_range(40)) - 20);
        thresh_off = W'(int'($urandom_range(40)) - 20);
      end
      for (int i = 0; i < CH; i++) begin
        sample[i*W +: W] = W'(int'($urandom_range(60)) - 30);
        sample_valid[i]  = ($urandom_range(3) != 0);
        ack[i]           = ($urandom_range(3) == 0);
      end
      reset = ($urandom_range(63) == 0);
      step();
      for (int i = 0; i < CH; i++) begin
        ew[i] = m_warn[i];
        ea[i] = m_alarm[i];
      end
      checks++;
      if (warn !== ew) begin errors++; $display("FAIL rand_warn n=%0d got %b want %b", n, warn, ew); end
      checks++;
      if (alarm_latched !== ea) begin errors++; $display("FAIL rand_alarm n=%0d got %b want %b", n, alarm_latched, ea); end
      checks++;
      if (warn_any !== m_any) begin errors++; $display("FAIL rand_any n=%0d got %b want %b", n, warn_any, m_any); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sample     = '0;
    thresh_on  = 32'sd10;
    thresh_off = 32'sd15;
    idle();
    test_reset();
    test_raise();
    test_break();
    test_hysteresis();
    test_invalid_hold();
    test_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_warn_monitor.md
# gas_warn_monitor

Multi-channel, parametrised gas-level warning monitor: the next generation of the single-channel gas warning FSM. Each channel compares a signed sample against a runtime-programmable hysteresis window. A warning must be confirmed by a debounce count of consecutive valid samples before it is raised or cleared. The block also keeps a per-channel sticky alarm that only an acknowledge clears. It sits between the sensor sampling front end and the operator alarm/indicator logic.

## Interface
Parameters:
- CHANNELS, 4: number of independent sensor channels (≥1).
- WIDTH, 32: sample and threshold width, signed two's complement.
- DEBOUNCE, 3: consecutive qualifying valid samples needed to change warning state (≥1).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- sample  in  CHANNELS*WIDTH  packed signed samples; channel i at bits [i*WIDTH +: WIDTH].
- sample_valid  in  CHANNELS  per-channel strobe; the sample is evaluated only when its bit is 1.
- thresh_on  in  WIDTH  signed; a sample < thresh_on is "low" and qualifies toward raising a warning.
- thresh_off  in  WIDTH  signed; a sample >= thresh_off is "recovered" and qualifies toward clearing a warning.
- ack  in  CHANNELS  per-channel sticky-alarm clear.
- warn  out  CHANNELS  debounced warning per channel, registered.
- warn_any  out  1  registered OR of warn.
- alarm_latched  out  CHANNELS  sticky: set when warn rises, cleared by ack.

## Operation
- Each channel has its own FSM and its own debounce counter. Counter width is $clog2(DEBOUNCE+1).
- FSM states: SAFE, PEND_WARN, WARN, PEND_SAFE.
  - SAFE: a valid low sample → PEND_WARN, cnt=1. If DEBOUNCE=1, go directly to WARN instead.
  - PEND_WARN: a valid low sample → cnt+1. When cnt reaches DEBOUNCE → WARN, cnt=0.
  - PEND_WARN: a valid non-low sample → SAFE, cnt=0. Consecutive means consecutive valid samples.
  - WARN and PEND_SAFE mirror the above, using "recovered" samples, returning to SAFE.
- Invalid cycles (sample_valid[i]=0) hold both state and cnt.
- In SAFE and PEND_WARN only the low test is evaluated. In WARN and PEND_SAFE only the recovered test is evaluated.
  - This keeps behaviour defined when thresh_off < thresh_on. No configuration error is flagged.
- warn[i]=1 exactly in states WARN and PEND_SAFE.
- alarm_latched[i] is set on the cycle warn[i] rises and cleared when ack[i]=1.
  - If set and ack coincide, set wins.
  - ack while warn stays high clears the latch. It is not re-set until the next rising edge of warn.
- Comparisons are fully signed at WIDTH bits. No saturation. Negative samples are legal.
- Thresholds are sampled on every cycle. Changing them mid-debounce affects only subsequent samples.

## Timing
- Reset values: warn=0, warn_any=0, alarm_latched=0, all FSMs SAFE, all cnt=0.
- Reset asserted mid-debounce or during WARN aborts immediately; outputs are 0 the cycle after the reset edge.
- Latency: warn rises on the clock edge that samples the DEBOUNCE-th consecutive valid low sample. It is visible the following cycle.
- alarm_latched rises in the same cycle as warn.
- warn_any lags warn by one cycle (registered OR).
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.
- The block has no backpressure. A valid sample is accepted every cycle.

## Structure
- The shared package holds:
  - the state enum (SAFE, PEND_WARN, WARN, PEND_SAFE), 2 bits;
  - the default constants for DEBOUNCE and WIDTH;
  - a helper function that computes the counter width.
- Sub-module gas_warn_channel implements one channel's FSM, counter and latch.
  - The top level generates CHANNELS instances, slices the packed sample bus, and registers warn_any.

## Test plan
(All with CHANNELS=4, DEBOUNCE=3, thresh_on=10, thresh_off=15.)
- Ch0 valid samples 9,8,7 → warn[0]=1 and alarm_latched[0]=1 the cycle after the third sample; warn_any=1 one cycle later.
- Ch1 samples 9,9,12,9,9 → warn[1] stays 0 (the 12 breaks the run). Then one more 9 → warn[1]=1.
- Ch0 in WARN, samples 12,13 (inside the hysteresis band) → warn stays 1. Then 15,20,16 → warn[0]=0.
- Ch2 samples 5,(valid=0 for 4 cycles),5,5 → warn[2] rises after the last 5 (invalid cycles hold).
- ack[0] asserted in the same cycle warn[0] rises → alarm_latched[0]=1 (set wins). ack[0] on the next cycle → 0, with warn[0] still 1.
- Ch3 in PEND_WARN with cnt=2, reset pulsed → all outputs 0. Then a single sample of 9 → warn[3] stays 0.
